// File: rtl/counter_pkg.sv
// Shared constants for the counter display path.
// Used by the segment decoders upstream and by the scanner.
//   SEG_W   : width of one seven-segment pattern
//   SEG_OFF : pattern with every segment dark (1 = segment off)
package counter_pkg;
  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
endpackage : counter_pkg

// File: rtl/counter_seg_scan_if.sv
// Bundle between the scanner and its driver.
//   i_en    : scan enable (low = freeze and blank)
//   i_seg   : DIGITS packed segment patterns, digit k at [7k+6:7k]
//   o_seg   : shared segment bus, 1 = segment off
//   o_an    : active-low digit enables
//   o_frame : one-cycle pulse on each snapshot load
// master = side that supplies patterns; slave = the scanner.
interface counter_seg_scan_if
  import counter_pkg::*;
#(
  parameter int DIGITS = 2
);
  logic                    i_en;
  logic [SEG_W*DIGITS-1:0] i_seg;
  logic [SEG_W-1:0]        o_seg;
  logic [DIGITS-1:0]       o_an;
  logic                    o_frame;

  modport master (output i_en, output i_seg, input o_seg, input o_an, input o_frame);
  modport slave  (input i_en, input i_seg, output o_seg, output o_an, output o_frame);
endinterface : counter_seg_scan_if

// File: rtl/counter_scan_div.sv
// Slot prescaler for the display scanner.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : count enable; low holds the count
//   o_tick         : high while the count sits on the last cycle of a slot
//   o_lit          : high once the blanking gap of the slot has elapsed
module counter_scan_div #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick,
  output logic o_lit
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt_r;

  assign o_tick = (cnt_r == CNT_W'(SCAN_DIV - 1));

  // With no blanking gap the compare would be constant, so tie it off.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign o_lit = 1'b1;
    end else begin : g_blank
      assign o_lit = (cnt_r >= CNT_W'(BLANK));
    end
  endgenerate

  // Slot counter: advances only while enabled, wraps at the end of the slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_en) begin
      if (o_tick) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule : counter_scan_div

// File: rtl/counter_seg_scan.sv
// Time-multiplexed seven-segment scanner.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : i_en, i_seg in; o_seg, o_an, o_frame out (all registered)
// Patterns are captured once per frame so a count change cannot tear the
// display; each digit slot opens with a blanking gap against ghosting.
module counter_seg_scan
  import counter_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  counter_seg_scan_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                    tick_s;
  logic                    lit_s;
  logic                    last_s;
  logic                    wrap_s;
  logic [IDX_W-1:0]        idx_r;
  logic [SEG_W*DIGITS-1:0] snap_r;
  logic [SEG_W-1:0]        seg_s;
  logic [DIGITS-1:0]       an_s;
  logic [SEG_W-1:0]        seg_r;
  logic [DIGITS-1:0]       an_r;
  logic                    frame_r;

  counter_scan_div #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK    (BLANK)
  ) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (bus.i_en),
    .o_tick  (tick_s),
    .o_lit   (lit_s)
  );

  assign last_s = (idx_r == IDX_W'(DIGITS - 1));
  assign wrap_s = bus.i_en && tick_s;

  // Next-output decode from the pre-edge slot state; disabled means dark.
  always_comb begin
    seg_s = SEG_OFF;
    an_s  = {DIGITS{1'b1}};
    if (bus.i_en && lit_s) begin
      seg_s = snap_r[int'(idx_r)*SEG_W +: SEG_W];
      for (int k = 0; k < DIGITS; k++) begin
        an_s[k] = (idx_r != IDX_W'(k));
      end
    end else begin
      seg_s = SEG_OFF;
      an_s  = {DIGITS{1'b1}};
    end
  end

  // Digit index and frame snapshot; snapshot loads only at the frame wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_r  <= {IDX_W{1'b0}};
      snap_r <= {(SEG_W*DIGITS){1'b1}};
    end else if (wrap_s) begin
      if (last_s) begin
        idx_r  <= {IDX_W{1'b0}};
        snap_r <= bus.i_seg;
      end else begin
        idx_r  <= idx_r + 1'b1;
      end
    end else begin
      idx_r  <= idx_r;
      snap_r <= snap_r;
    end
  end

  // Output registers, one cycle behind the slot state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_r   <= SEG_OFF;
      an_r    <= {DIGITS{1'b1}};
      frame_r <= 1'b0;
    end else begin
      seg_r   <= seg_s;
      an_r    <= an_s;
      frame_r <= wrap_s && last_s;
    end
  end

  assign bus.o_seg   = seg_r;
  assign bus.o_an    = an_r;
  assign bus.o_frame = frame_r;
endmodule : counter_seg_scan

// File: tb/tb_counter_seg_scan.sv
// Directed bench: a 2-digit scanner (SCAN_DIV=4, BLANK=1), a 1-digit one
// (SCAN_DIV=2, BLANK=0) and an 8-digit one (SCAN_DIV=2, BLANK=1) share
// clock and reset. Inputs change 1 time unit after a rising edge and
// outputs are read at that same point.
module tb_counter_seg_scan;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   e;

  counter_seg_scan_if #(.DIGITS(2)) bus_a ();
  counter_seg_scan_if #(.DIGITS(1)) bus_b ();
  counter_seg_scan_if #(.DIGITS(8)) bus_c ();

  counter_seg_scan #(.DIGITS(2), .SCAN_DIV(4), .BLANK(1)) dut_a (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bus_a.slave));
  counter_seg_scan #(.DIGITS(1), .SCAN_DIV(2), .BLANK(0)) dut_b (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bus_b.slave));
  counter_seg_scan #(.DIGITS(8), .SCAN_DIV(2), .BLANK(1)) dut_c (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bus_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [1:0] an, input logic [6:0] seg,
                       input logic fr);
    check({tag, "_an"},    32'(bus_a.o_an),    32'(an));
    check({tag, "_seg"},   32'(bus_a.o_seg),   32'(seg));
    check({tag, "_frame"}, 32'(bus_a.o_frame), 32'(fr));
  endtask

  // One clock: step past the edge, then check the two edge-parameter DUTs
  // for the first 32 edges after reset release.
  task automatic adv();
    logic [7:0] an_c;
    @(posedge clk);
    #1;
    e++;
    if (e <= 32) begin
      check("d1_an", 32'(bus_b.o_an), 32'(1'b0));
      check("d1_frame", 32'(bus_b.o_frame), 32'((e % 2) == 0));
      check("d1_seg", 32'(bus_b.o_seg), (e <= 2) ? 32'h7F : 32'h06);
      if ((e % 2) == 1) begin
        an_c = 8'hFF;
      end else begin
        an_c = ~(8'h01 << (((e / 2) - 1) % 8));
      end
      check("d8_an", 32'(bus_c.o_an), 32'(an_c));
      check("d8_onelow", 32'($countones(~bus_c.o_an) <= 1), 32'd1);
    end
  endtask

  logic [1:0] an_tab [8];
  logic [6:0] d0;
  logic [6:0] d1;
  logic [6:0] sx;

  initial begin
    total = 0;
    bad   = 0;
    e     = 0;
    an_tab = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    rst_n = 1'b0;
    bus_a.i_en = 1'b0; bus_a.i_seg = {7'h30, 7'h40};
    bus_b.i_en = 1'b0; bus_b.i_seg = 7'h06;
    bus_c.i_en = 1'b0; bus_c.i_seg = {8{7'h11}};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk_a("rst", 2'b11, 7'h7F, 1'b0);
    check("rst_d1_an", 32'(bus_b.o_an), 32'd1);
    check("rst_d8_an", 32'(bus_c.o_an), 32'hFF);

    rst_n = 1'b1;
    bus_a.i_en = 1'b1;
    bus_b.i_en = 1'b1;
    bus_c.i_en = 1'b1;

    // Frames 1..3: all-off, then 40/30, then 24/79 after a mid-frame change
    for (int f = 0; f < 3; f++) begin
      d0 = (f == 0) ? 7'h7F : (f == 1) ? 7'h40 : 7'h24;
      d1 = (f == 0) ? 7'h7F : (f == 1) ? 7'h30 : 7'h79;
      for (int p = 0; p < 8; p++) begin
        adv();
        sx = (an_tab[p] == 2'b11) ? 7'h7F : (an_tab[p] == 2'b10) ? d0 : d1;
        chk_a($sformatf("f%0d_p%0d", f, p), an_tab[p], sx, p == 7);
        if (f == 1 && p == 2) bus_a.i_seg = {7'h79, 7'h24};
      end
    end

    // Frame 4 up to digit 1's first lit cycle
    for (int p = 0; p < 6; p++) begin
      adv();
      sx = (an_tab[p] == 2'b11) ? 7'h7F : (an_tab[p] == 2'b10) ? 7'h24 : 7'h79;
      chk_a($sformatf("f3_p%0d", p), an_tab[p], sx, 1'b0);
    end

    // Freeze for 5 cycles during digit 1's lit window
    bus_a.i_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adv();
      chk_a($sformatf("frz%0d", i), 2'b11, 7'h7F, 1'b0);
    end
    bus_a.i_en = 1'b1;
    adv(); chk_a("resume0", 2'b01, 7'h79, 1'b0);
    adv(); chk_a("resume1", 2'b01, 7'h79, 1'b1);
    adv(); chk_a("next_blank", 2'b11, 7'h7F, 1'b0);
    adv(); chk_a("next_d0", 2'b10, 7'h24, 1'b0);

    // Asynchronous reset between edges, mid lit window
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 2'b11, 7'h7F, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Restart from cnt=0, idx=0 with snapshot back to all-off
    @(posedge clk); #1;
    chk_a("post_rst0", 2'b11, 7'h7F, 1'b0);
    @(posedge clk); #1;
    chk_a("post_rst1", 2'b10, 7'h7F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule : tb_counter_seg_scan
